// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: per-source level/edge capture into sticky EVENT bits,
// masking, and a coalescing engine (event-count threshold plus timeout) driving irq_o.
module uart_irq_ctrl #(
   parameter int IRQ_NUM = 9,
   parameter int CNT_W   = 8,
   parameter int TMO_W   = 16
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [IRQ_NUM-1:0] src_i,
   input  logic               reg_wr_i,
   input  logic               reg_rd_i,
   input  logic [2:0]         reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o,
   output logic               irq_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FIRE    = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IRQ_NUM-1:0] event_q, event_d;
   logic [IRQ_NUM-1:0] mask_q, mask_d;
   logic [IRQ_NUM-1:0] en_q, en_d;
   logic [IRQ_NUM-1:0] mode_q, mode_d;
   logic [IRQ_NUM-1:0] src_q;
   logic [CNT_W-1:0]   thr_q, thr_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmr_q, tmr_d;
   logic               irq_q, irq_d;
   logic [31:0]        rdata_q, rdata_d;

   logic [IRQ_NUM-1:0] wr_bits;
   logic [IRQ_NUM-1:0] hit;
   logic [IRQ_NUM-1:0] w1c;
   logic [IRQ_NUM-1:0] pending;
   logic               new_evt;
   logic [CNT_W-1:0]   cnt_inc;
   logic [CNT_W-1:0]   thr_eff;
   logic [TMO_W-1:0]   tmr_inc;
   logic               cnt_hit;
   logic               tmo_hit;
   logic [31:0]        coal_rd;
   logic [31:0]        rd_val;
   logic               unused_wdata;

   assign unused_wdata = ^reg_wdata_i;

   // Register file, capture and read path
   always_comb begin
      wr_bits = reg_wdata_i[IRQ_NUM-1:0];
      hit     = en_q & ((mode_q & src_i & ~src_q) | (~mode_q & src_i));
      w1c     = (reg_wr_i && reg_addr_i == 3'd0) ? wr_bits : '0;
      event_d = (event_q & ~w1c) | hit;
      pending = event_q & mask_q;
      new_evt = |(hit & mask_q & ~event_q);

      mask_d = (reg_wr_i && reg_addr_i == 3'd1) ? wr_bits : mask_q;
      en_d   = (reg_wr_i && reg_addr_i == 3'd2) ? wr_bits : en_q;
      mode_d = (reg_wr_i && reg_addr_i == 3'd3) ? wr_bits : mode_q;
      thr_d  = (reg_wr_i && reg_addr_i == 3'd4) ? reg_wdata_i[CNT_W-1:0] : thr_q;
      tmo_d  = (reg_wr_i && reg_addr_i == 3'd4) ? reg_wdata_i[16 +: TMO_W] : tmo_q;

      coal_rd                = '0;
      coal_rd[CNT_W-1:0]     = thr_q;
      coal_rd[16 +: TMO_W]   = tmo_q;

      // Reads see the pre-write contents, so a same-cycle write never leaks through
      case (reg_addr_i)
         3'd0:    rd_val = 32'(event_q);
         3'd1:    rd_val = 32'(mask_q);
         3'd2:    rd_val = 32'(en_q);
         3'd3:    rd_val = 32'(mode_q);
         3'd4:    rd_val = coal_rd;
         3'd5:    rd_val = 32'(pending);
         default: rd_val = '0;
      endcase
      rdata_d = reg_rd_i ? rd_val : rdata_q;
   end

   // Coalescing state machine
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      tmr_d   = '0;
      cnt_inc = cnt_q;
      if (new_evt && cnt_q != '1) cnt_inc = cnt_q + CNT_W'(1);
      tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + TMO_W'(1);
      thr_eff = (thr_q == '0) ? CNT_W'(1) : thr_q;
      cnt_hit = cnt_inc >= thr_eff;
      tmo_hit = (tmo_q != '0) && (({1'b0, tmr_q} + (TMO_W+1)'(1)) >= {1'b0, tmo_q});

      case (state_q)
         IDLE: begin
            if (new_evt) begin
               if (thr_q <= CNT_W'(1)) begin
                  state_d = FIRE;
               end else begin
                  state_d = COLLECT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         COLLECT: begin
            if (pending == '0) begin
               state_d = IDLE;
            end else if (cnt_hit || tmo_hit) begin
               state_d = FIRE;
            end else begin
               cnt_d = cnt_inc;
               tmr_d = tmr_inc;
            end
         end
         FIRE: begin
            if (pending == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      irq_d = (state_d == FIRE);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         event_q <= '0;
         mask_q  <= '0;
         en_q    <= '0;
         mode_q  <= '0;
         src_q   <= '0;
         thr_q   <= '0;
         tmo_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         irq_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         event_q <= event_d;
         mask_q  <= mask_d;
         en_q    <= en_d;
         mode_q  <= mode_d;
         src_q   <= src_i;
         thr_q   <= thr_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
      end
   end

   assign reg_rdata_o = rdata_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Bench for uart_irq_ctrl: directed scenarios then random traffic, every cycle's
// irq_o and reg_rdata_o checked against a behavioural model through expected queues.
module tb_uart_irq_ctrl;

   localparam int N  = 9;
   localparam int CW = 8;
   localparam int TW = 16;
   localparam logic [N-1:0] ALL = '1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [N-1:0]  src = '0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [2:0]    addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic          irq;

   always #5 clk = ~clk;

   uart_irq_ctrl #(.IRQ_NUM(N), .CNT_W(CW), .TMO_W(TW)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .src_i       (src),
      .reg_wr_i    (wr),
      .reg_rd_i    (rd),
      .reg_addr_i  (addr),
      .reg_wdata_i (wdata),
      .reg_rdata_o (rdata),
      .irq_o       (irq)
   );

   // Scoreboard
   logic [31:0] exp_q[$];
   logic        exp_irq_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   // Reference model: software-visible registers plus the coalescing phase
   // (0 = waiting, 1 = gathering events, 2 = interrupt asserted)
   logic [N-1:0] m_ev, m_mask, m_en, m_mode, m_prev;
   int           m_thr, m_tmo, m_phase, m_count, m_age;
   logic [31:0]  m_rdata;
   logic [N-1:0] cur_src = '0;

   function automatic void model_step(input logic r, input logic [N-1:0] s, input logic w,
                                      input logic rr, input logic [2:0] a, input logic [31:0] d);
      logic [N-1:0] hit, clr, pend_old;
      logic         newly;
      int           cnt_new, thr_e;
      if (!r) begin
         m_ev = '0; m_mask = '0; m_en = '0; m_mode = '0; m_prev = '0;
         m_thr = 0; m_tmo = 0; m_phase = 0; m_count = 0; m_age = 0;
         m_rdata = '0;
         return;
      end
      pend_old = m_ev & m_mask;
      if (rr) begin
         case (a)
            3'd0: m_rdata = 32'(m_ev);
            3'd1: m_rdata = 32'(m_mask);
            3'd2: m_rdata = 32'(m_en);
            3'd3: m_rdata = 32'(m_mode);
            3'd4: m_rdata = 32'((m_tmo << 16) | m_thr);
            3'd5: m_rdata = 32'(pend_old);
            default: m_rdata = '0;
         endcase
      end
      hit = '0;
      for (int i = 0; i < N; i++) begin
         if (m_en[i]) begin
            if (m_mode[i]) hit[i] = s[i] && !m_prev[i];
            else           hit[i] = s[i];
         end
      end
      newly = |(hit & m_mask & ~m_ev);
      clr   = (w && a == 3'd0) ? d[N-1:0] : '0;

      case (m_phase)
         0: if (newly) begin
               if (m_thr <= 1) m_phase = 2;
               else begin m_phase = 1; m_count = 1; m_age = 0; end
            end
         1: begin
               cnt_new = m_count + (newly ? 1 : 0);
               if (cnt_new > 255) cnt_new = 255;
               thr_e = (m_thr == 0) ? 1 : m_thr;
               if (pend_old == '0) begin
                  m_phase = 0; m_count = 0; m_age = 0;
               end else if (cnt_new >= thr_e || (m_tmo != 0 && m_age + 1 >= m_tmo)) begin
                  m_phase = 2; m_count = 0; m_age = 0;
               end else begin
                  m_count = cnt_new;
                  if (m_age < 65535) m_age = m_age + 1;
               end
            end
         default: if (pend_old == '0) m_phase = 0;
      endcase

      m_ev = (m_ev & ~clr) | hit;
      if (w && a == 3'd1) m_mask = d[N-1:0];
      if (w && a == 3'd2) m_en   = d[N-1:0];
      if (w && a == 3'd3) m_mode = d[N-1:0];
      if (w && a == 3'd4) begin
         m_thr = int'(d[7:0]);
         m_tmo = int'(d[31:16]);
      end
      m_prev = s;
   endfunction

   // Driver tasks: inputs change on the falling edge, expectations queued alongside
   task automatic step(input logic r, input logic [N-1:0] s, input logic w, input logic rr,
                       input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      rstn = r; src = s; wr = w; rd = rr; addr = a; wdata = d;
      model_step(r, s, w, rr, a, d);
      exp_q.push_back(m_rdata);
      exp_irq_q.push_back(m_phase == 2);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, cur_src, 1'b0, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic wreg(input logic [2:0] a, input logic [31:0] d);
      step(1'b1, cur_src, 1'b1, 1'b0, a, d);
   endtask

   task automatic rreg(input logic [2:0] a);
      step(1'b1, cur_src, 1'b0, 1'b1, a, 32'd0);
   endtask

   task automatic pulse(input logic [N-1:0] bits);
      step(1'b1, cur_src | bits, 1'b0, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic reset_cyc();
      cur_src = '0;
      step(1'b0, '0, 1'b0, 1'b0, 3'd0, 32'd0);
   endtask

   // Monitor: irq_o and reg_rdata_o are registered, so they are compared every cycle
   initial begin
      logic        e_irq;
      logic [31:0] e_rd;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_irq_q.size() > 0) begin
            e_irq = exp_irq_q.pop_front();
            e_rd  = exp_q.pop_front();
            total++;
            if (irq !== e_irq) begin
               bad++;
               $display("FAIL irq cycle %0d: got %b expected %b", cyc, irq, e_irq);
            end
            total++;
            if (rdata !== e_rd) begin
               bad++;
               $display("FAIL rdata cycle %0d: got %h expected %h", cyc, rdata, e_rd);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r;
      logic [2:0]  a;
      logic [31:0] d;

      // Reset state and empty register map
      reset_cyc();
      for (int i = 0; i < 8; i++) rreg(3'(i));

      // Immediate fire, W1C clears, PENDING reads 0
      wreg(3'd2, 32'h1FF); wreg(3'd1, 32'h1FF); wreg(3'd3, 32'h0); wreg(3'd4, 32'h0);
      pulse(9'h002); idle(2); rreg(3'd0);
      wreg(3'd0, 32'h002); idle(1); rreg(3'd5); idle(2);

      // Edge mode: held source sets once; clearing while high stays clear
      wreg(3'd3, 32'h001);
      cur_src = 9'h001; idle(4); rreg(3'd0);
      wreg(3'd0, 32'h001); idle(3); rreg(3'd0);
      cur_src = '0; idle(1); wreg(3'd0, 32'h1FF); idle(2);
      // Level mode: held source re-sets after the clear
      wreg(3'd3, 32'h000);
      cur_src = 9'h001; idle(3); wreg(3'd0, 32'h001); idle(1); rreg(3'd0);
      cur_src = '0; idle(1); wreg(3'd0, 32'h1FF); idle(3);

      // Threshold 3, no timeout; repeat on a set bit does not count
      wreg(3'd4, 32'h0000_0003);
      pulse(9'h001); idle(4); pulse(9'h001); idle(4); pulse(9'h002); idle(4);
      pulse(9'h004); idle(3); rreg(3'd5); wreg(3'd0, 32'h1FF); idle(3);

      // Threshold 4, timeout 20: timer fires, W1C returns to idle
      wreg(3'd4, 32'h0014_0004); rreg(3'd4);
      pulse(9'h008); idle(24); wreg(3'd0, 32'h008); idle(3);

      // Masked source captured but silent; set beats a same-cycle W1C
      wreg(3'd4, 32'h0); wreg(3'd1, 32'h1FB);
      pulse(9'h004); idle(2); rreg(3'd0); rreg(3'd5);
      wreg(3'd0, 32'h1FF); wreg(3'd1, 32'h1FF); idle(2);
      step(1'b1, 9'h020, 1'b1, 1'b0, 3'd0, 32'h020); idle(1); rreg(3'd0);
      wreg(3'd0, 32'h1FF); idle(2);

      // Reset mid-interrupt, then index 7 and same-cycle read/write
      pulse(9'h080); idle(2);
      reset_cyc();
      rreg(3'd0); rreg(3'd1); rreg(3'd2); rreg(3'd7);
      wreg(3'd7, 32'hFFFF_FFFF); rreg(3'd7);
      step(1'b1, '0, 1'b1, 1'b1, 3'd1, 32'h0000_0155); rreg(3'd1);
      wreg(3'd1, 32'hFFFF_FFFF); rreg(3'd1);

      // Randomised traffic
      for (int k = 0; k < 2500; k++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            reset_cyc();
         end else if (r < 22) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd4)
               d = ((($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25))) << 16)
                   | 32'($urandom_range(0, 5));
            if ((a == 3'd1 || a == 3'd2) && $urandom_range(0, 1) == 1) d = 32'h1FF;
            step(1'b1, cur_src, 1'b1, ($urandom_range(0, 3) == 0), a, d);
         end else if (r < 37) begin
            rreg(3'($urandom_range(0, 7)));
         end else begin
            if ($urandom_range(0, 3) == 0) cur_src = N'($urandom & $urandom & $urandom) & ALL;
            idle(1);
         end
      end
      idle(2);

      repeat (3) @(posedge clk);
      #2;
      total++;
      if (exp_irq_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_irq_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
